// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 memory bus.
// State codes, read-owner tags and bus widths.
package z80_bus_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [0:0] S_CPU = 1'b0;
  localparam logic [0:0] S_DMA = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } own_t;
endpackage

// File: rtl/z80_rd_pipe.sv
// Read return path: owner-tag delay line and per-port rdata capture.
// Memory data is sampled in the last cycle of the read latency.
module z80_rd_pipe
  import z80_bus_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  own_t              tag_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata
);

  own_t cap;
  logic cpu_rv_q;
  logic dma_rv_q;

  generate
    if (RD_LAT == 1) begin : g_l1
      assign cap = tag_in;
    end else begin : g_ln
      own_t sh [RD_LAT-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RD_LAT-1; i++)
            sh[i] <= OWN_NONE;
        end else begin
          sh[0] <= tag_in;
          for (int i = 1; i < RD_LAT-1; i++)
            sh[i] <= sh[i-1];
        end
      end
      assign cap = sh[RD_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rv_q  <= 1'b0;
      dma_rv_q  <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      cpu_rv_q <= (cap == OWN_CPU);
      dma_rv_q <= (cap == OWN_DMA);
      if (cap == OWN_CPU) cpu_rdata <= mem_rdata;
      if (cap == OWN_DMA) dma_rdata <= mem_rdata;
    end
  end

  // A read that finished just before reset must not be reported.
  assign cpu_rvalid = cpu_rv_q & ~rst;
  assign dma_rvalid = dma_rv_q & ~rst;

endmodule

// File: rtl/z80_mem_arbiter.sv
// CPU/DMA arbiter for the shared 64 KB byte memory.
// CPU first, with a starvation counter that forces bounded DMA bursts.
module z80_mem_arbiter
  import z80_bus_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int DMA_BURST  = 2,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpu_req,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_cpu_we,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dma_req,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  input  logic              i_dma_we,
  output logic              o_dma_gnt,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  logic [0:0] state, state_nx;
  logic [7:0] streak, streak_nx;
  logic [7:0] burst, burst_nx;
  logic       both;
  own_t       tag;

  assign both = i_cpu_req & i_dma_req;

  always_comb begin
    o_cpu_gnt = 1'b0;
    o_dma_gnt = 1'b0;
    state_nx  = state;
    streak_nx = streak;
    burst_nx  = burst;
    if (!rst) begin
      unique case (1'b1)
        (state == S_CPU): begin
          o_cpu_gnt = i_cpu_req;
          o_dma_gnt = i_dma_req & ~i_cpu_req;
          if (both) begin
            if (streak == 8'(STARVE_MAX-1)) begin
              state_nx  = S_DMA;
              streak_nx = '0;
            end else begin
              streak_nx = streak + 8'd1;
            end
          end else if (!i_dma_req) begin
            streak_nx = '0;
          end
        end
        (state == S_DMA): begin
          o_dma_gnt = i_dma_req;
          o_cpu_gnt = i_cpu_req & ~i_dma_req;
          if (i_dma_req && burst != 8'(DMA_BURST-1)) begin
            burst_nx = burst + 8'd1;
          end else begin
            state_nx = S_CPU;
            burst_nx = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_CPU;
      streak <= '0;
      burst  <= '0;
    end else begin
      state  <= state_nx;
      streak <= streak_nx;
      burst  <= burst_nx;
    end
  end

  assign o_mem_addr  = o_dma_gnt ? i_dma_addr : i_cpu_addr;
  assign o_mem_wdata = o_dma_gnt ? i_dma_wdata : i_cpu_wdata;
  assign o_mem_we    = (o_cpu_gnt & i_cpu_we) | (o_dma_gnt & i_dma_we);

  always_comb begin
    tag = OWN_NONE;
    if (o_cpu_gnt & ~i_cpu_we)
      tag = OWN_CPU;
    else if (o_dma_gnt & ~i_dma_we)
      tag = OWN_DMA;
  end

  z80_rd_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (tag),
    .mem_rdata (i_mem_rdata),
    .cpu_rvalid(o_cpu_rvalid),
    .cpu_rdata (o_cpu_rdata),
    .dma_rvalid(o_dma_rvalid),
    .dma_rdata (o_dma_rdata)
  );

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Bench for z80_mem_arbiter: RD_LAT=1 and RD_LAT=3 copies on shared stimulus.
// Read results are scoreboarded by expected return cycle.
module tb_z80_mem_arbiter;

  typedef struct {
    int         cyc;
    bit         dma;
    logic [7:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;

  logic        c_gnt1, c_rv1, d_gnt1, d_rv1, m_we1;
  logic [7:0]  c_rd1, d_rd1, m_wd1, m_rd1;
  logic [15:0] m_addr1;
  logic        c_gnt3, c_rv3, d_gnt3, d_rv3, m_we3;
  logic [7:0]  c_rd3, d_rd3, m_wd3, m_rd3;
  logic [15:0] m_addr3;

  logic [7:0] mem1 [65536];
  logic [7:0] mem3 [65536];
  logic [7:0] shadow [65536];
  logic [7:0] p1, p2;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  bit   h1, h3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  z80_mem_arbiter #(.STARVE_MAX(4), .DMA_BURST(2), .RD_LAT(1)) u_l1 (
    .clk(clk), .rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_we(cpu_we),
    .o_cpu_gnt(c_gnt1), .o_cpu_rvalid(c_rv1), .o_cpu_rdata(c_rd1),
    .i_dma_req(dma_req), .i_dma_addr(dma_addr),
    .i_dma_wdata(dma_wdata), .i_dma_we(dma_we),
    .o_dma_gnt(d_gnt1), .o_dma_rvalid(d_rv1), .o_dma_rdata(d_rd1),
    .o_mem_addr(m_addr1), .o_mem_wdata(m_wd1), .o_mem_we(m_we1),
    .i_mem_rdata(m_rd1)
  );

  z80_mem_arbiter #(.STARVE_MAX(4), .DMA_BURST(2), .RD_LAT(3)) u_l3 (
    .clk(clk), .rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_we(cpu_we),
    .o_cpu_gnt(c_gnt3), .o_cpu_rvalid(c_rv3), .o_cpu_rdata(c_rd3),
    .i_dma_req(dma_req), .i_dma_addr(dma_addr),
    .i_dma_wdata(dma_wdata), .i_dma_we(dma_we),
    .o_dma_gnt(d_gnt3), .o_dma_rvalid(d_rv3), .o_dma_rdata(d_rd3),
    .o_mem_addr(m_addr3), .o_mem_wdata(m_wd3), .o_mem_we(m_we3),
    .i_mem_rdata(m_rd3)
  );

  assign m_rd1 = mem1[m_addr1];
  always @(posedge clk) if (m_we1) mem1[m_addr1] <= m_wd1;

  always @(posedge clk) begin
    if (m_we3) mem3[m_addr3] <= m_wd3;
    p1 <= mem3[m_addr3];
    p2 <= p1;
  end
  assign m_rd3 = p2;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic mon(input string tag, input bit has, input exp_t e,
                     input logic cv, input logic dv,
                     input logic [7:0] cd, input logic [7:0] dd);
    if (has) begin
      chk({tag, "_cpu_rvalid"}, 32'(cv), 32'(!e.dma));
      chk({tag, "_dma_rvalid"}, 32'(dv), 32'(e.dma));
      chk({tag, "_rdata"}, 32'(e.dma ? dd : cd), 32'(e.d));
    end else if (cv | dv) begin
      chk({tag, "_spurious_rvalid"}, {30'd0, cv, dv}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    h1 = q1.size() > 0 && q1[0].cyc == cyc;
    e1 = '{0, 1'b0, 8'h00};
    if (h1) e1 = q1.pop_front();
    mon("l1", h1, e1, c_rv1, d_rv1, c_rd1, d_rd1);
    h3 = q3.size() > 0 && q3[0].cyc == cyc;
    e3 = '{0, 1'b0, 8'h00};
    if (h3) e3 = q3.pop_front();
    mon("l3", h3, e3, c_rv3, d_rv3, c_rd3, d_rd3);
  end

  task automatic drive(input bit cr, input logic [15:0] ca, input bit cw,
                       input logic [7:0] cd, input bit dr,
                       input logic [15:0] da, input bit dw,
                       input logic [7:0] dd);
    cpu_req = cr; cpu_addr = ca; cpu_we = cw; cpu_wdata = cd;
    dma_req = dr; dma_addr = da; dma_we = dw; dma_wdata = dd;
  endtask

  // Check one cycle's grant/mux outputs, then book any granted read.
  task automatic expect_cyc(input string tag, input bit ecg, input bit edg);
    logic [15:0] ea;
    logic        ew;
    @(negedge clk);
    ea = edg ? dma_addr : cpu_addr;
    ew = (ecg & cpu_we) | (edg & dma_we);
    chk({tag, "_cgnt1"}, 32'(c_gnt1), 32'(ecg));
    chk({tag, "_dgnt1"}, 32'(d_gnt1), 32'(edg));
    chk({tag, "_addr1"}, 32'(m_addr1), 32'(ea));
    chk({tag, "_we1"}, 32'(m_we1), 32'(ew));
    chk({tag, "_cgnt3"}, 32'(c_gnt3), 32'(ecg));
    chk({tag, "_dgnt3"}, 32'(d_gnt3), 32'(edg));
    chk({tag, "_addr3"}, 32'(m_addr3), 32'(ea));
    chk({tag, "_we3"}, 32'(m_we3), 32'(ew));
    if (ew) chk({tag, "_wdata"}, 32'(m_wd1),
                32'(edg ? dma_wdata : cpu_wdata));
    if (ecg && !cpu_we) begin
      q1.push_back('{cyc + 1, 1'b0, shadow[cpu_addr]});
      q3.push_back('{cyc + 3, 1'b0, shadow[cpu_addr]});
    end
    if (edg && !dma_we) begin
      q1.push_back('{cyc + 1, 1'b1, shadow[dma_addr]});
      q3.push_back('{cyc + 3, 1'b1, shadow[dma_addr]});
    end
    if (ecg && cpu_we) shadow[cpu_addr] = cpu_wdata;
    if (edg && dma_we) shadow[dma_addr] = dma_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    for (int i = 0; i < n; i++) expect_cyc("idle", 0, 0);
  endtask

  task automatic contend(input string tag, input int n, input int first);
    drive(1, 16'h1111, 0, 8'h00, 1, 16'h2222, 0, 8'h00);
    for (int i = first; i < first + n; i++)
      expect_cyc(tag, (i % 6) < 4, (i % 6) >= 4);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      shadow[i] = 8'(i * 7 + 3);
      mem1[i] = shadow[i];
      mem3[i] = shadow[i];
    end
    shadow[16'h0100] = 8'h3E;
    mem1[16'h0100] = 8'h3E;
    mem3[16'h0100] = 8'h3E;

    rst = 1'b1;
    drive(1, 16'h0100, 0, 8'h00, 1, 16'h2222, 1, 8'h11);
    @(posedge clk); #1;
    expect_cyc("rst", 0, 0);
    chk("rst_crd1", 32'(c_rd1), 32'h0);
    chk("rst_drd3", 32'(d_rd3), 32'h0);
    rst = 1'b0;

    // CPU-only read
    drive(1, 16'h0100, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    expect_cyc("t1", 1, 0);
    idle(4);

    // DMA write, then CPU reads it back
    drive(0, 16'h0000, 0, 8'h00, 1, 16'h4000, 1, 8'hA5);
    expect_cyc("t3w", 0, 1);
    drive(1, 16'h4000, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    expect_cyc("t3r", 1, 0);
    idle(4);

    // back-to-back CPU reads
    drive(1, 16'h0010, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    expect_cyc("t4a", 1, 0);
    drive(1, 16'h0011, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    expect_cyc("t4b", 1, 0);
    idle(4);

    contend("t2", 12, 0);
    idle(4);

    // reset right after a granted read during contention
    contend("t5a", 2, 0);
    rst = 1'b1;
    q1.delete();
    q3.delete();
    expect_cyc("t5rst", 0, 0);
    expect_cyc("t5rst", 0, 0);
    rst = 1'b0;
    drive(0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    chk("t5_crd1", 32'(c_rd1), 32'h0);
    chk("t5_drd1", 32'(d_rd1), 32'h0);
    chk("t5_crd3", 32'(c_rd3), 32'h0);
    chk("t5_drd3", 32'(d_rd3), 32'h0);
    contend("t5b", 6, 0);
    idle(4);

    // DMA drops out after a single forced grant
    contend("t6a", 5, 0);
    drive(1, 16'h0123, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    expect_cyc("t6drop", 1, 0);
    contend("t6b", 5, 0);
    idle(6);

    chk("q1_drain", q1.size(), 0);
    chk("q3_drain", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
